// File: rtl/vdp_vram_arbiter.sv
// Three-way VRAM port arbiter for sprite, background and CPU requesters.
// One access per cycle, registered RAM strobes, fixed two-cycle read return.
module vdp_vram_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblank,
  input  logic        spr_req,
  input  logic [13:0] spr_addr,
  input  logic        bg_req,
  input  logic [13:0] bg_addr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        spr_gnt,
  output logic        bg_gnt,
  output logic        cpu_gnt,
  output logic        ram_en,
  output logic        ram_we,
  output logic [13:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  rdata,
  output logic        spr_rvalid,
  output logic        bg_rvalid,
  output logic        cpu_rvalid
);

  typedef enum logic {StActive, StBlank} mode_e;
  typedef enum logic [1:0] {IdSpr, IdBg, IdCpu} req_id_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  mode_e       mode_q, mode_d;
  logic        blank_mode;
  logic [3:0]  starve_q, starve_d;
  logic        promoted;
  logic        any_gnt;
  logic        rd_gnt;
  logic [13:0] gnt_addr;
  req_id_e     gnt_id;
  logic        ram_en_q, ram_we_q;
  logic [13:0] ram_addr_q;
  logic [7:0]  ram_wdata_q;
  logic        tag1_valid_q;
  req_id_e     tag1_id_q;
  logic [2:0]  rvalid_q, rvalid_d;

  // Display mode FSM: follows vblank one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= StActive;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      StActive: if (vblank)  mode_d = StBlank;
      StBlank:  if (!vblank) mode_d = StActive;
    endcase
  end

  always_comb begin
    blank_mode = (mode_q == StBlank);
  end

  assign promoted = (starve_q == StarveMax);

  // CPU first in BLANK or when starved; otherwise spr > bg > cpu.
  always_comb begin
    spr_gnt = 1'b0;
    bg_gnt  = 1'b0;
    cpu_gnt = 1'b0;
    if (!rst) begin
      if (cpu_req && (blank_mode || promoted)) cpu_gnt = 1'b1;
      else if (spr_req)                        spr_gnt = 1'b1;
      else if (bg_req)                         bg_gnt  = 1'b1;
      else if (cpu_req)                        cpu_gnt = 1'b1;
    end
  end

  always_comb begin
    gnt_addr = cpu_addr;
    gnt_id   = IdCpu;
    if (spr_gnt) begin
      gnt_addr = spr_addr;
      gnt_id   = IdSpr;
    end else if (bg_gnt) begin
      gnt_addr = bg_addr;
      gnt_id   = IdBg;
    end
  end

  assign any_gnt = spr_gnt | bg_gnt | cpu_gnt;
  assign rd_gnt  = any_gnt & ~(cpu_gnt & cpu_we);

  always_comb begin
    starve_d = '0;
    if (cpu_req && !cpu_gnt) begin
      starve_d = promoted ? starve_q : starve_q + 4'd1;
    end
  end

  always_comb begin
    rvalid_d = '0;
    if (tag1_valid_q) begin
      unique case (tag1_id_q)
        IdSpr:   rvalid_d[0] = 1'b1;
        IdBg:    rvalid_d[1] = 1'b1;
        IdCpu:   rvalid_d[2] = 1'b1;
        default: rvalid_d    = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q     <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      tag1_valid_q <= 1'b0;
      tag1_id_q    <= IdSpr;
      rvalid_q     <= '0;
    end else begin
      starve_q <= starve_d;
      ram_en_q <= any_gnt;
      ram_we_q <= cpu_gnt & cpu_we;
      // Address and data hold across idle cycles.
      if (any_gnt) begin
        ram_addr_q  <= gnt_addr;
        ram_wdata_q <= cpu_gnt ? cpu_wdata : 8'h00;
      end
      tag1_valid_q <= rd_gnt;
      tag1_id_q    <= gnt_id;
      rvalid_q     <= rvalid_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign rdata      = ram_rdata;
  assign spr_rvalid = rvalid_q[0];
  assign bg_rvalid  = rvalid_q[1];
  assign cpu_rvalid = rvalid_q[2];

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Bench for vdp_vram_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_vdp_vram_arbiter;

  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst, vblank;
  logic        spr_req, bg_req, cpu_req, cpu_we;
  logic [13:0] spr_addr, bg_addr, cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        spr_gnt, bg_gnt, cpu_gnt;
  logic        ram_en, ram_we;
  logic [13:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata, rdata;
  logic        spr_rvalid, bg_rvalid, cpu_rvalid;

  vdp_vram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .vblank(vblank),
    .spr_req(spr_req), .spr_addr(spr_addr),
    .bg_req(bg_req), .bg_addr(bg_addr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .spr_gnt(spr_gnt), .bg_gnt(bg_gnt), .cpu_gnt(cpu_gnt),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .rdata(rdata),
    .spr_rvalid(spr_rvalid), .bg_rvalid(bg_rvalid), .cpu_rvalid(cpu_rvalid)
  );

  always #5 clk = ~clk;

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [7:0] dflt(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]};
  endfunction

  bit [7:0] vram    [16384];
  bit       vram_wr [16384];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        vram[ram_addr]    <= ram_wdata;
        vram_wr[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= vram_wr[ram_addr] ? vram[ram_addr] : dflt(ram_addr);
      end
    end
  end

  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  bit [7:0] mmem [16384];
  bit       mwr  [16384];
  int       m_starve = 0;
  bit       m_blank = 1'b0;
  bit       e_en = 1'b0, e_we = 1'b0;
  bit [13:0] e_addr = '0;
  bit [7:0]  e_wdata = '0;
  bit [2:0]  slot_v [4];
  bit [7:0]  slot_d [4];
  bit [2:0]  m_gnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: priority list per cycle, in-order access log, reads return two cycles later.
  task automatic model_eval();
    int        order [3];
    bit  [2:0] reqs, eg;
    bit [13:0] ga;
    int        s;
    s = cyc % 4;
    chk("ram_en", 32'(ram_en), 32'(e_en));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    chk("rvalid", 32'({cpu_rvalid, bg_rvalid, spr_rvalid}), 32'(slot_v[s]));
    if (slot_v[s] != 3'b000) chk("rdata", 32'(rdata), 32'(slot_d[s]));
    slot_v[s] = '0;

    reqs = {cpu_req, bg_req, spr_req};
    if (m_blank || m_starve == STARVE_MAX) order = '{2, 0, 1};
    else                                   order = '{0, 1, 2};
    eg = '0;
    if (!rst) begin
      foreach (order[i]) if (eg == 3'b000 && reqs[order[i]]) eg[order[i]] = 1'b1;
    end
    chk("grant", 32'({cpu_gnt, bg_gnt, spr_gnt}), 32'(eg));

    if (rst) begin
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
      slot_v[(cyc + 1) % 4] = '0;
      slot_v[(cyc + 2) % 4] = '0;
      m_starve = 0;
      m_blank = 1'b0;
    end else begin
      ga = eg[0] ? spr_addr : eg[1] ? bg_addr : cpu_addr;
      e_en = (eg != 3'b000);
      e_we = eg[2] && cpu_we;
      if (e_en) begin
        e_addr  = ga;
        e_wdata = eg[2] ? cpu_wdata : 8'h00;
        if (e_we) begin
          mmem[ga] = cpu_wdata;
          mwr[ga]  = 1'b1;
        end else begin
          slot_v[(cyc + 2) % 4] = eg;
          slot_d[(cyc + 2) % 4] = mwr[ga] ? mmem[ga] : dflt(ga);
        end
      end
      if (cpu_req && !eg[2]) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else                   m_starve = 0;
      m_blank = vblank;
    end
    m_gnt = eg;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; vblank = 1'b0;
    spr_req = 1'b0; bg_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    spr_addr = '0; bg_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) begin step(); nxt(); end
    rst = 1'b0;
    repeat (2) begin step(); nxt(); end

    // Sprite beats background; both read back in order.
    spr_req = 1'b1; spr_addr = 14'h3F00; bg_req = 1'b1; bg_addr = 14'h3800;
    step(); chk("d1_spr_gnt", 32'(spr_gnt), 32'd1); chk("d1_bg_wait", 32'(bg_gnt), 32'd0); nxt();
    spr_req = 1'b0;
    step(); chk("d1_ram_addr", 32'(ram_addr), 32'h3F00); chk("d1_bg_gnt", 32'(bg_gnt), 32'd1); nxt();
    bg_req = 1'b0;
    step(); chk("d1_spr_rvalid", 32'(spr_rvalid), 32'd1); chk("d1_spr_rdata", 32'(rdata), 32'h3F); nxt();
    step(); chk("d1_bg_rvalid", 32'(bg_rvalid), 32'd1); chk("d1_bg_rdata", 32'(rdata), 32'h38); nxt();

    // Starved CPU write wins on its ninth request cycle.
    spr_req = 1'b1; spr_addr = 14'h0100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 8'hA5;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("d2_cpu_gnt", 32'(cpu_gnt), 32'(k == 9));
      chk("d2_spr_gnt", 32'(spr_gnt), 32'(k != 9));
      nxt();
    end
    spr_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    chk("d2_ram_we", 32'(ram_we), 32'd1);
    chk("d2_ram_wdata", 32'(ram_wdata), 32'hA5);
    chk("d2_ram_addr", 32'(ram_addr), 32'h0010);
    nxt();
    step(); chk("d2_no_rvalid", 32'(cpu_rvalid), 32'd0); nxt();
    step(); chk("d2_no_rvalid2", 32'(cpu_rvalid), 32'd0); nxt();

    // BLANK mode: CPU ahead of background once the mode has registered.
    vblank = 1'b1;
    step(); nxt();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010; bg_req = 1'b1; bg_addr = 14'h0200;
    step(); chk("d3_cpu_gnt", 32'(cpu_gnt), 32'd1); chk("d3_bg_wait", 32'(bg_gnt), 32'd0); nxt();
    cpu_req = 1'b0;
    step(); chk("d3_bg_gnt", 32'(bg_gnt), 32'd1); nxt();
    bg_req = 1'b0;
    step(); chk("d3_cpu_rvalid", 32'(cpu_rvalid), 32'd1); chk("d3_rdata", 32'(rdata), 32'hA5); nxt();
    vblank = 1'b0;
    repeat (2) begin step(); nxt(); end

    // Write then immediate read of the same address.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1234; cpu_wdata = 8'h5A;
    step(); chk("d4_cpu_gnt", 32'(cpu_gnt), 32'd1); nxt();
    cpu_req = 1'b0; cpu_we = 1'b0; spr_req = 1'b1; spr_addr = 14'h1234;
    step(); chk("d4_spr_gnt", 32'(spr_gnt), 32'd1); nxt();
    spr_req = 1'b0;
    step(); nxt();
    step(); chk("d4_spr_rvalid", 32'(spr_rvalid), 32'd1); chk("d4_rdata", 32'(rdata), 32'h5A); nxt();

    // Reset with a read in flight.
    spr_req = 1'b1; spr_addr = 14'h0300;
    step(); chk("d5_spr_gnt", 32'(spr_gnt), 32'd1); nxt();
    rst = 1'b1;
    step(); chk("d5_gnt_in_rst", 32'({cpu_gnt, bg_gnt, spr_gnt}), 32'd0); nxt();
    rst = 1'b0; spr_req = 1'b0; bg_req = 1'b1; bg_addr = 14'h0040;
    step();
    chk("d5_rvalid_t2", 32'(spr_rvalid), 32'd0);
    chk("d5_ram_en", 32'(ram_en), 32'd0);
    chk("d5_ram_we", 32'(ram_we), 32'd0);
    chk("d5_ram_addr", 32'(ram_addr), 32'd0);
    chk("d5_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("d5_bg_gnt", 32'(bg_gnt), 32'd1);
    nxt();
    bg_req = 1'b0;
    step(); chk("d5_rvalid_t3", 32'(spr_rvalid), 32'd0); nxt();

    // Randomized traffic: requests held until granted, occasional drops and resets.
    for (int n = 0; n < 4000; n++) begin
      step();
      nxt();
      if (m_gnt[0]) spr_req = 1'b0;
      if (m_gnt[1]) bg_req  = 1'b0;
      if (m_gnt[2]) cpu_req = 1'b0;
      if (rst) rst = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 39) == 0) vblank = ~vblank;
      if (!spr_req) begin
        if ($urandom_range(0, 3) != 0) begin
          spr_req = 1'b1; spr_addr = 14'($urandom_range(0, 63));
        end
      end else if ($urandom_range(0, 19) == 0) spr_req = 1'b0;
      if (!bg_req) begin
        if ($urandom_range(0, 2) != 0) begin
          bg_req = 1'b1; bg_addr = 14'($urandom_range(0, 63));
        end
      end else if ($urandom_range(0, 19) == 0) bg_req = 1'b0;
      if (!cpu_req) begin
        if ($urandom_range(0, 3) == 0) begin
          cpu_req   = 1'b1;
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = 14'($urandom_range(0, 63));
          cpu_wdata = 8'($urandom_range(0, 255));
        end
      end else if ($urandom_range(0, 29) == 0) cpu_req = 1'b0;
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
